// File: rtl/strength_net_resolver_if.sv
// Event-queue handshake bundle for strength_net_resolver: the resolver is the
// master (producer), the consumer is the slave.
interface strength_net_resolver_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          evt_valid;
    logic          evt_ready;
    logic [3:0]    evt_data;
    logic [CW-1:0] evt_count;

    modport master (output evt_valid, evt_data, evt_count, input evt_ready);
    modport slave  (input evt_valid, evt_data, evt_count, output evt_ready);
endinterface

// File: rtl/strength_net_resolver.sv
// Strength-resolved multi-driver net receiver: resolve, register, stability-filter,
// queue committed level changes. Define NET_PULL0_EN to add an implicit pull-0 driver.
module strength_net_resolver #(
    parameter int N_DRV      = 4,
    parameter int STB_CYCLES = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_DRV-1:0]       drv_val,
    input  logic [3*N_DRV-1:0]     drv_str,
    output logic [1:0]             res_lvl,
    output logic [1:0]             lvl_o,
    output logic                   ovf,
    input  logic                   ovf_clr,
    strength_net_resolver_if.master evt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0]    STB  = 4'(STB_CYCLES);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        LVL_0 = 2'b00,
        LVL_1 = 2'b01,
        LVL_Z = 2'b10,
        LVL_X = 2'b11
    } lvl_t;

    lvl_t       res_nxt, res_q, lvl_q, cand_q;
    logic [2:0] smax;
    logic       seen0, seen1;
    logic [3:0] cnt_q, cnt_inc;
    logic       commit;

    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          full, do_push, do_pop;

    // Only drivers at the maximum strength participate; everything weaker is ignored.
    always_comb begin
        smax  = '0;
        seen0 = 1'b0;
        seen1 = 1'b0;
        for (int unsigned i = 0; i < N_DRV; i++) begin
            if (drv_str[3*i +: 3] > smax) smax = drv_str[3*i +: 3];
        end
`ifdef NET_PULL0_EN
        if (smax < 3'd5) smax = 3'd5;
`endif
        for (int unsigned i = 0; i < N_DRV; i++) begin
            if (smax != 3'd0 && drv_str[3*i +: 3] == smax) begin
                if (drv_val[i]) seen1 = 1'b1;
                else            seen0 = 1'b1;
            end
        end
`ifdef NET_PULL0_EN
        if (smax == 3'd5) seen0 = 1'b1;
`endif
        if (smax == 3'd0)          res_nxt = LVL_Z;
        else if (seen0 && seen1)   res_nxt = LVL_X;
        else if (seen1)            res_nxt = LVL_1;
        else                       res_nxt = LVL_0;
    end

    // Counter value this edge would produce; reaching STB commits on the same edge.
    always_comb begin
        cnt_inc = (res_q == cand_q) ? cnt_q + 4'd1 : 4'd1;
        commit  = (res_q != lvl_q) && (cnt_inc >= STB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= LVL_Z;
            lvl_q  <= LVL_Z;
            cand_q <= LVL_Z;
            cnt_q  <= '0;
        end else begin
            res_q <= res_nxt;
            if (res_q == lvl_q) begin
                cnt_q <= '0;
            end else begin
                cand_q <= res_q;
                if (commit) begin
                    lvl_q <= res_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_inc;
                end
            end
        end
    end

    assign res_lvl = res_q;
    assign lvl_o   = lvl_q;

    always_comb begin
        full    = (count == FULL);
        do_pop  = (count != '0) && evt.evt_ready;
        do_push = commit && (!full || do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= {lvl_q, res_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
            // A drop on the same edge as a clear keeps the flag set.
            if (commit && !do_push) ovf <= 1'b1;
            else if (ovf_clr)       ovf <= 1'b0;
        end
    end

    assign evt.evt_valid = (count != '0);
    assign evt.evt_count = count;
    assign evt.evt_data  = (count != '0) ? mem[rptr] : '0;

endmodule

// File: doc/strength_net_resolver.md
Name: strength_net_resolver

Overview:
- Receiving end of a multi-driver net whose drivers carry strength specifiers. Each driver presents a value plus a 3-bit strength.
- Resolves the net per strength-dominance rules and registers the result. The result then passes a stability filter before it is committed as the net level.
- Each committed level change is queued as an event in a small FIFO with valid/ready handshake.
- Used as the bench-side reference for checking strength-resolved nets in the signal-strength test suite.

Parameters:
- N_DRV, 4, number of drivers (1..8).
- STB_CYCLES, 3, consecutive resolved samples required before commit (1..15).
- FIFO_DEPTH, 4, event FIFO entries (power of 2, >=2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- drv_val  input  N_DRV  driven value per driver.
- drv_str  input  3*N_DRV  strength per driver, driver i at [3i+2:3i]. 0=highz, 1=small, 2=medium, 3=weak, 4=large, 5=pull, 6=strong, 7=supply.
- res_lvl  output  2  registered resolved level, unfiltered.
- lvl_o  output  2  committed, filtered level.
- evt_valid  output  1  event FIFO non-empty.
- evt_ready  input  1  consumer accepts the head event.
- evt_data  output  4  head event: {old_lvl[1:0], new_lvl[1:0]}.
- evt_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- ovf  output  1  sticky overflow flag.
- ovf_clr  input  1  clears ovf.

Behaviour:
- Level encoding: 2'b00=0, 2'b01=1, 2'b10=Z, 2'b11=X.
- Reset (rst_n low, asynchronous):
  - res_lvl=Z, lvl_o=Z.
  - Filter counter=0, candidate=Z.
  - FIFO empty: evt_valid=0, evt_data=0, evt_count=0.
  - ovf=0.
- Resolution (combinational, registered into res_lvl at each edge; 1-cycle latency):
  - smax = maximum drv_str over all drivers.
  - smax==0 -> Z.
  - Otherwise, every driver with strength==smax drives the same value v -> v.
  - Otherwise (conflict at the top strength) -> X.
  - Weaker drivers are ignored entirely.
- Stability filter (evaluated every edge on res_lvl):
  - res_lvl==lvl_o: counter=0.
  - res_lvl!=lvl_o and res_lvl==candidate: counter increments, saturating at STB_CYCLES.
  - res_lvl!=lvl_o and res_lvl!=candidate: candidate=res_lvl, counter=1.
  - When the counter reaches STB_CYCLES, on that same edge: lvl_o<=candidate, counter=0, and event {old lvl_o, candidate} is pushed.
  - With STB_CYCLES=1, lvl_o follows res_lvl one cycle later.
  - Input change to lvl_o change latency = STB_CYCLES+1 cycles, provided the input stays stable.
- Event FIFO:
  - Show-ahead: evt_data is valid whenever evt_valid=1.
  - Pop occurs when evt_valid && evt_ready.
  - Push while full with no pop: event dropped, ovf<=1.
  - Push and pop on the same edge while full: both succeed, no overflow.
  - Push and pop on the same edge while empty: pop is ignored (evt_valid=0), push succeeds.
  - Pointers wrap modulo FIFO_DEPTH.
- ovf_clr: clears ovf on the next edge. If an overflow occurs on that same edge, ovf stays 1 (set wins).
- Reset asserted mid-count or with a non-empty FIFO: all state is discarded immediately. No event is generated for the return to Z.

Optional Feature:
- NET_PULL0_EN defined: an implicit internal driver with value 0 and strength 5 (pull) joins resolution.
  - An undriven net resolves to 0, not Z.
  - Pull-strength 1 drivers conflict with it and resolve to X.
  - Reset values of res_lvl, lvl_o and candidate remain Z, so the first settle generates event Z->0.
- Not defined: no implicit driver; resolution exactly as above.

Test Plan:
- N_DRV=2, drv0 = 1 @ strong(6), drv1 = 0 @ pull(5), held 5 cycles after reset -> res_lvl=01 after 1 cycle; lvl_o=01 after 4 cycles; one event 4'b1001.
- drv0 = 1 @ 6, drv1 = 0 @ 6 -> res_lvl=11; after STB_CYCLES=3 more cycles lvl_o=11; event 4'b0111 (previous level 1).
- Glitch: from committed 0, drive 1 @ 6 for 2 cycles, then back to 0 -> lvl_o stays 00, no event pushed.
- Candidate switch: from 0, res_lvl 1 for 2 cycles then X for 3 -> lvl_o goes directly to 11; single event 4'b0011.
- FIFO_DEPTH=4, evt_ready=0, force 5 committed changes -> evt_count=4, ovf=1, first 4 events intact in order. Then pulse ovf_clr and drain with evt_ready=1 -> ovf=0, evt_count counts 4->0.
- rst_n low for 1 cycle mid-count with 2 events queued -> evt_valid=0, lvl_o=Z, no event on release. With NET_PULL0_EN and all drivers at strength 0 -> lvl_o=00, event 4'b1000.
